// File: rtl/moving_avg_filter_mc.sv
// Multi-channel moving-average filter over the last 2^LOG2N samples of each channel.
// Latency: 1 cycle from input accept to registered output.
// Backpressure: in_ready drops while an unaccepted output is held or clear is high.
module moving_avg_filter_mc #(
  parameter int WIDTH = 16,
  parameter int LOG2N = 4,
  parameter int CH    = 4,
  localparam int CHW  = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             cfg_round,
  input  logic             cfg_early,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CHW-1:0]   in_ch,
  input  logic [WIDTH-1:0] in_sample,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CHW-1:0]   out_ch,
  output logic [WIDTH-1:0] out_sample
);

  localparam int N  = 1 << LOG2N;
  localparam int SW = WIDTH + LOG2N;

  localparam logic [LOG2N:0] N_L   = (LOG2N+1)'(N);
  localparam logic [LOG2N:0] NM1   = N_L - 1'b1;
  localparam logic [CHW:0]   CH_L  = (CHW+1)'(CH);
  localparam logic [SW:0]    HALF  = (SW+1)'(1) << (LOG2N - 1);

  // Per-channel state: sample ring, write pointer, fill count, running sum.
  logic [WIDTH-1:0] win [CH][N];
  logic [LOG2N-1:0] ptr [CH];
  logic [LOG2N:0]   cnt [CH];
  logic [SW-1:0]    sum [CH];

  logic             accept;
  logic             in_range;
  logic             produce;
  logic [CHW-1:0]   cidx;
  logic [WIDTH-1:0] old_smp;
  logic [SW-1:0]    next_sum;
  logic [SW:0]      rnd_sum;
  logic [WIDTH-1:0] avg;

  assign in_ready = !clear && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Datapath: new running sum, rounded/truncated average, output decision.
  always_comb begin
    in_range = ({1'b0, in_ch} < CH_L);
    // Out-of-range IDs are steered to channel 0 only to keep indexing legal;
    // nothing is written for them.
    cidx     = in_range ? in_ch : '0;
    old_smp  = win[cidx][ptr[cidx]];
    next_sum = sum[cidx]
             + {{LOG2N{in_sample[WIDTH-1]}}, in_sample}
             - {{LOG2N{old_smp[WIDTH-1]}}, old_smp};
    // One extra bit so adding the half-LSB cannot overflow at the positive extreme.
    rnd_sum  = {next_sum[SW-1], next_sum} + (cfg_round ? HALF : '0);
    avg      = WIDTH'($signed(rnd_sum) >>> LOG2N);
    // Count is checked before the update, so the N-th sample is the first to output.
    produce  = cfg_early || (cnt[cidx] >= NM1);
  end

  // Channel state update on accepted, in-range samples; clear wipes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CH; c++) begin
        for (int i = 0; i < N; i++) win[c][i] <= '0;
        ptr[c] <= '0;
        cnt[c] <= '0;
        sum[c] <= '0;
      end
    end else if (clear) begin
      for (int c = 0; c < CH; c++) begin
        for (int i = 0; i < N; i++) win[c][i] <= '0;
        ptr[c] <= '0;
        cnt[c] <= '0;
        sum[c] <= '0;
      end
    end else if (accept && in_range) begin
      win[cidx][ptr[cidx]] <= in_sample;
      ptr[cidx]            <= ptr[cidx] + 1'b1;
      if (cnt[cidx] != N_L) cnt[cidx] <= cnt[cidx] + 1'b1;
      sum[cidx]            <= next_sum;
    end
  end

  // Output register: load on a producing accept, drop valid once taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_ch     <= '0;
      out_sample <= '0;
    end else if (clear) begin
      out_valid  <= 1'b0;
      out_ch     <= '0;
      out_sample <= '0;
    end else if (accept && in_range && produce) begin
      out_valid  <= 1'b1;
      out_ch     <= in_ch;
      out_sample <= avg;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_moving_avg_filter_mc.sv
// Self-checking bench for moving_avg_filter_mc (WIDTH=16, LOG2N=4, CH=3).
// Expected averages come from a shift-register history model per channel,
// queued at accept time and compared when the DUT hands an output over.
module tb_moving_avg_filter_mc;

  localparam int W = 16;
  localparam int L = 4;
  localparam int C = 3;
  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        cfg_round;
  logic        cfg_early;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_ch;
  logic [15:0] in_sample;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_ch;
  logic [15:0] out_sample;

  moving_avg_filter_mc #(.WIDTH(W), .LOG2N(L), .CH(C)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .cfg_round  (cfg_round),
    .cfg_early  (cfg_early),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_ch      (in_ch),
    .in_sample  (in_sample),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ch     (out_ch),
    .out_sample (out_sample)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  ch;
    logic [15:0] smp;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   n_out  = 0;
  int   last_ch;
  int   last_smp;

  int   hist [C][N];
  int   hcnt [C];

  // Output monitor: every handshake must match the oldest queued expectation.
  always @(negedge clk) begin
    #2;
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: got ch=%0d sample=%0d, expected no output", out_ch, $signed(out_sample));
      end else begin
        mon_e = sbq.pop_front();
        if (out_ch !== mon_e.ch || out_sample !== mon_e.smp) begin
          errors++;
          $display("FAIL scoreboard: got ch=%0d sample=%0d, expected ch=%0d sample=%0d",
                   out_ch, $signed(out_sample), mon_e.ch, $signed(mon_e.smp));
        end
      end
      last_ch  = int'(out_ch);
      last_smp = int'($signed(out_sample));
      n_out++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_clear();
    for (int c = 0; c < C; c++) begin
      hcnt[c] = 0;
      for (int i = 0; i < N; i++) hist[c][i] = 0;
    end
  endtask

  // Present one sample, wait (bounded) for acceptance, update model and scoreboard.
  task automatic send(input int ch, input int s);
    int  tries;
    int  tot;
    int  a;
    bit  prod;
    exp_t e;
    in_valid  = 1'b1;
    in_ch     = ch[1:0];
    in_sample = s[15:0];
    #1;
    tries = 0;
    while (!in_ready && tries < 50) begin
      @(negedge clk);
      #1;
      tries++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready=%0b after %0d cycles, expected 1", in_ready, tries);
    end else if (ch < C) begin
      prod = cfg_early || (hcnt[ch] >= N - 1);
      for (int i = N - 1; i > 0; i--) hist[ch][i] = hist[ch][i-1];
      hist[ch][0] = s;
      if (hcnt[ch] < N) hcnt[ch]++;
      tot = 0;
      for (int i = 0; i < N; i++) tot += hist[ch][i];
      a = cfg_round ? ((tot + N/2) >>> L) : (tot >>> L);
      if (prod) begin
        e.ch  = ch[1:0];
        e.smp = a[15:0];
        sbq.push_back(e);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic settle();
    #3;
  endtask

  // Synchronous clear with a sample presented that must not be taken.
  task automatic do_clear();
    clear     = 1'b1;
    in_valid  = 1'b1;
    in_ch     = 2'd0;
    in_sample = 16'h1234;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL clear_in_ready: got %0b, expected 0", in_ready); end
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL clear_out_valid: got %0b, expected 0", out_valid); end
    model_clear();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; cfg_round = 1'b0; cfg_early = 1'b0;
    in_valid = 1'b0; in_ch = '0; in_sample = '0; out_ready = 1'b1;
    model_clear();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b, expected 0", out_valid); end
    checks++;
    if (out_ch !== 2'd0) begin errors++; $display("FAIL reset_out_ch: got %0d, expected 0", out_ch); end
    checks++;
    if (out_sample !== 16'd0) begin errors++; $display("FAIL reset_out_sample: got %0d, expected 0", out_sample); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b, expected 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_warmup();
    int n0;
    cfg_early = 1'b0; cfg_round = 1'b0;
    n0 = n_out;
    for (int i = 0; i < 15; i++) send(0, 100);
    settle();
    checks++;
    if (n_out !== n0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL warmup_silent: outputs=%0d out_valid=%0b, expected 0 and 0", n_out - n0, out_valid);
    end
    send(0, 100);
    settle();
    checks++;
    if (n_out !== n0 + 1 || last_ch !== 0 || last_smp !== 100) begin
      errors++; $display("FAIL warmup_16th: n=%0d ch=%0d avg=%0d, expected 1 0 100", n_out - n0, last_ch, last_smp);
    end
    send(0, 116);
    settle();
    checks++;
    if (last_smp !== 101) begin errors++; $display("FAIL warmup_17th: got %0d, expected 101", last_smp); end
  endtask

  task automatic test_rounding();
    do_clear();
    cfg_early = 1'b0; cfg_round = 1'b0;
    for (int i = 0; i < 16; i++) send(0, (i < 8) ? 3 : 0);
    settle();
    checks++;
    if (last_smp !== 1) begin errors++; $display("FAIL round_pos_trunc: got %0d, expected 1", last_smp); end
    cfg_round = 1'b1;
    send(0, 3);
    settle();
    checks++;
    if (last_smp !== 2) begin errors++; $display("FAIL round_pos_round: got %0d, expected 2", last_smp); end
    do_clear();
    cfg_round = 1'b0;
    for (int i = 0; i < 16; i++) send(0, (i < 8) ? -3 : 0);
    settle();
    checks++;
    if (last_smp !== -2) begin errors++; $display("FAIL round_neg_trunc: got %0d, expected -2", last_smp); end
    cfg_round = 1'b1;
    send(0, -3);
    settle();
    checks++;
    if (last_smp !== -1) begin errors++; $display("FAIL round_neg_round: got %0d, expected -1", last_smp); end
  endtask

  task automatic test_extremes();
    do_clear();
    cfg_round = 1'b0;
    for (int i = 0; i < 16; i++) send(0, -32768);
    settle();
    checks++;
    if (last_smp !== -32768) begin errors++; $display("FAIL ext_min: got %0d, expected -32768", last_smp); end
    send(0, 32767);
    settle();
    checks++;
    if (last_smp !== -28673) begin errors++; $display("FAIL ext_mix_trunc: got %0d, expected -28673", last_smp); end
    do_clear();
    cfg_round = 1'b1;
    for (int i = 0; i < 15; i++) send(0, -32768);
    send(0, 32767);
    settle();
    checks++;
    if (last_smp !== -28672) begin errors++; $display("FAIL ext_mix_round: got %0d, expected -28672", last_smp); end
    do_clear();
    cfg_round = 1'b1;
    for (int i = 0; i < 16; i++) send(1, 32767);
    settle();
    checks++;
    if (last_smp !== 32767 || last_ch !== 1) begin
      errors++; $display("FAIL ext_max: got ch=%0d avg=%0d, expected ch=1 avg=32767", last_ch, last_smp);
    end
    cfg_round = 1'b0;
  endtask

  task automatic test_interleave();
    int n0;
    do_clear();
    cfg_early = 1'b0; cfg_round = 1'b0;
    n0 = n_out;
    for (int i = 0; i < 40; i++) begin
      send(i % 2, (i % 2) ? -1000 : 1000);
      if (i == 10 || i == 31) send(3, 7777);
    end
    settle();
    checks++;
    if (n_out !== n0 + 10 || last_ch !== 1 || last_smp !== -1000) begin
      errors++; $display("FAIL interleave: n=%0d ch=%0d avg=%0d, expected 10 1 -1000", n_out - n0, last_ch, last_smp);
    end
  endtask

  task automatic test_backpressure();
    int n0;
    n0 = n_out;
    send(0, 1000);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ch     = 2'd1;
    in_sample = 16'(-1000);
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_ch !== 2'd0 || out_sample !== 16'd1000) begin
        errors++;
        $display("FAIL bp_hold[%0d]: in_ready=%0b out_valid=%0b ch=%0d smp=%0d, expected 0 1 0 1000",
                 k, in_ready, out_valid, out_ch, $signed(out_sample));
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    send(1, -1000);
    send(0, 1000);
    settle();
    checks++;
    if (n_out !== n0 + 3 || last_ch !== 0 || last_smp !== 1000) begin
      errors++; $display("FAIL bp_resume: n=%0d ch=%0d avg=%0d, expected 3 0 1000", n_out - n0, last_ch, last_smp);
    end
  endtask

  task automatic test_early();
    cfg_early = 1'b1; cfg_round = 1'b0;
    do_clear();
    send(1, 160);
    settle();
    checks++;
    if (last_ch !== 1 || last_smp !== 10) begin
      errors++; $display("FAIL early_first: ch=%0d avg=%0d, expected ch=1 avg=10", last_ch, last_smp);
    end
    for (int i = 0; i < 7; i++) send(1, 160);
    settle();
    checks++;
    if (last_smp !== 80) begin errors++; $display("FAIL early_8th: got %0d, expected 80", last_smp); end
    do_clear();
    send(1, 160);
    settle();
    checks++;
    if (last_smp !== 10) begin errors++; $display("FAIL early_after_clear: got %0d, expected 10", last_smp); end
  endtask

  task automatic test_reset_mid();
    cfg_early = 1'b1;
    send(1, 160);
    send(1, 160);
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_ch !== 2'd0 || out_sample !== 16'd0) begin
      errors++; $display("FAIL rst_mid: valid=%0b ch=%0d smp=%0d, expected 0 0 0", out_valid, out_ch, out_sample);
    end
    sbq.delete();
    model_clear();
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    send(1, 160);
    settle();
    checks++;
    if (last_ch !== 1 || last_smp !== 10) begin
      errors++; $display("FAIL rst_mid_restart: ch=%0d avg=%0d, expected ch=1 avg=10", last_ch, last_smp);
    end
  endtask

  initial begin
    test_reset();
    test_warmup();
    test_rounding();
    test_extremes();
    test_interleave();
    test_backpressure();
    test_early();
    test_reset_mid();
    repeat (3) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin errors++; $display("FAIL leftover: %0d expected outputs never seen, expected 0", sbq.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
